adder_arbiter: RTL
==================

Name: adder_arbiter

Overview:
- Shares one pipelined 8-bit adder instance between NUM_REQ requesters.
- Each requester offers an (a, b) operand pair on a valid/ready handshake.
- A round-robin arbiter issues one operand pair per cycle to the adder and tags it with the requester ID.
- The sum is returned on a shared response bus with the originating ID, fixed latency after acceptance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID; must satisfy 2**ID_W >= NUM_REQ.
- ADD_LAT, 1, adder latency in cycles from registered a/b input to valid res (1..4).

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous reset, active-low.
- hold_i  in  1  when 1, no new grants are issued; in-flight operations still complete.
- req_valid_i  in  NUM_REQ  per-requester operand valid.
- req_a_i  in  NUM_REQ*8  operand a; requester i at bits [8i+7:8i].
- req_b_i  in  NUM_REQ*8  operand b; same packing as req_a_i.
- req_ready_o  out  NUM_REQ  per-requester accept strobe; at most one bit set (onehot0).
- add_a_o  out  8  registered operand a to the adder.
- add_b_o  out  8  registered operand b to the adder.
- add_res_i  in  8  adder result.
- rsp_valid_o  out  1  response valid; single-cycle pulse per operation.
- rsp_id_o  out  ID_W  requester ID of the current response.
- rsp_data_o  out  8  sum, (a + b) mod 256.
- busy_o  out  1  1 while any operation is in flight.

Behaviour:
Reset (reset_i = 0, asynchronous):
- add_a_o = add_b_o = 0, rsp_valid_o = 0, rsp_id_o = 0, busy_o = 0.
- Round-robin pointer = 0, so requester 0 has highest priority first.
- Tag pipeline cleared; req_ready_o = 0.
- Reset mid-operation discards all in-flight operations; no response is produced for them.

Handshake:
- A transfer occurs on a rising edge where req_valid_i[i] = 1 and req_ready_o[i] = 1.
- Requesters hold valid and operands stable until accepted; the block never retracts a request.
- req_ready_o is combinational from req_valid_i, hold_i and the pointer. No backpressure on responses.

Arbitration:
- Scan requesters starting at the pointer, wrapping from NUM_REQ-1 to 0. The first with valid = 1 is granted.
- After a grant to requester g, pointer = (g + 1) mod NUM_REQ. With no grant, the pointer is unchanged.
- hold_i = 1 forces req_ready_o = 0. The pointer is frozen, but the pipeline keeps draining.

Pipeline, with a grant on edge t:
- add_a_o/add_b_o take the granted operands at t and are valid for cycle t+1. Otherwise they keep their previous value; the adder result is ignored.
- Tag pipeline: a (valid, ID) shift register of depth 1 + ADD_LAT.
- rsp_valid_o = 1 in cycle t+1+ADD_LAT, with rsp_id_o = g and rsp_data_o = add_res_i (combinational pass-through).
- rsp_id_o holds its last value when rsp_valid_o = 0.
- Throughput: one operation per cycle. Back-to-back grants produce back-to-back responses in grant order.

busy_o:
- OR of all tag-pipeline valid bits, registered with the pipeline.
- Simultaneous grant and drain in the same cycle keeps busy_o = 1.

Arithmetic:
- Result is 8 bits, carry discarded. Wrap-around, e.g. 0xFF + 0x01 = 0x00, is normal and not flagged.

Optional Feature:
Macro: ADDER_ARB_STATS_EN
- Defined: adds output grant_cnt_o, NUM_REQ*16 bits, one 16-bit counter per requester.
  - Increments on each accepted transfer and saturates at 0xFFFF.
  - Cleared by reset.
  - Adds input stats_clr_i (1 bit), a synchronous clear that takes priority over an increment in the same cycle.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Single request, ADD_LAT = 1: req0 valid with a = 0x12, b = 0x34 at cycle 0 -> req_ready_o = 0001 at cycle 0; add_a_o = 0x12 at cycle 1; rsp_valid_o = 1, rsp_id_o = 0, rsp_data_o = 0x46 at cycle 2; busy_o falls afterwards.
- All 4 requesters valid continuously from reset -> grants in order 0, 1, 2, 3, 0 on consecutive cycles; responses carry IDs 0, 1, 2, 3, 0 with no gaps.
- Wrap-around: a = 0xFF, b = 0x01 -> rsp_data_o = 0x00; a = 0x80, b = 0x80 -> 0x00.
- hold_i = 1 with req2 valid for 5 cycles -> req_ready_o = 0 throughout and the in-flight response still emitted; on hold release, req2 is granted in the same cycle.
- Reset pulse (reset_i = 0) one cycle after a grant, ADD_LAT = 2 -> no rsp_valid_o ever for that operation; busy_o = 0 immediately; pointer back to 0.
- ADDER_ARB_STATS_EN defined: 3 grants to req1, then stats_clr_i = 1 in the same cycle as a 4th grant -> grant_cnt_o[31:16] = 0 next cycle.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin front end sharing one external pipelined 8-bit adder between NUM_REQ requesters.
// Optional per-requester grant counters are compiled in with `define ADDER_ARB_STATS_EN.
module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ADD_LAT = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 hold_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*8-1:0] req_a_i,
    input  logic [NUM_REQ*8-1:0] req_b_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [7:0]           add_a_o,
    output logic [7:0]           add_b_o,
    input  logic [7:0]           add_res_i,
    output logic                 rsp_valid_o,
    output logic [ID_W-1:0]      rsp_id_o,
    output logic [7:0]           rsp_data_o,
    output logic                 busy_o
`ifdef ADDER_ARB_STATS_EN
    ,
    input  logic                  stats_clr_i,
    output logic [NUM_REQ*16-1:0] grant_cnt_o
`endif
);

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_vld;
    logic [NUM_REQ-1:0] gnt;

    // Scan from the pointer with wrap; first valid requester wins.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_vld && req_valid_i[(int'(ptr) + i) % NUM_REQ]) begin
                gnt_vld = 1'b1;
                gnt_id  = ID_W'((int'(ptr) + i) % NUM_REQ);
            end
        end
        if (hold_i || !reset_i) gnt_vld = 1'b0;
        if (gnt_vld) gnt[gnt_id] = 1'b1;
    end

    assign req_ready_o = gnt;

    // Tag pipeline: stage k holds the op whose operands were issued k+1 cycles ago.
    logic [ADD_LAT:0]           vld_pipe;
    logic [ADD_LAT:0][ID_W-1:0] id_pipe;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ptr      <= '0;
            add_a_o  <= '0;
            add_b_o  <= '0;
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe   <= {vld_pipe[ADD_LAT-1:0], gnt_vld};
            id_pipe[0] <= gnt_id;
            for (int k = 1; k < ADD_LAT; k++) id_pipe[k] <= id_pipe[k-1];
            // Last stage only loads on a valid op so rsp_id_o holds between responses.
            if (vld_pipe[ADD_LAT-1]) id_pipe[ADD_LAT] <= id_pipe[ADD_LAT-1];
            if (gnt_vld) begin
                add_a_o <= req_a_i[8*gnt_id +: 8];
                add_b_o <= req_b_i[8*gnt_id +: 8];
                ptr     <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
            end
        end
    end

    assign rsp_valid_o = vld_pipe[ADD_LAT];
    assign rsp_id_o    = id_pipe[ADD_LAT];
    assign rsp_data_o  = add_res_i;
    assign busy_o      = |vld_pipe;

`ifdef ADDER_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] cnt;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stats_clr_i) cnt[i] <= '0;
                else if (gnt[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
            end
        end
    end

    assign grant_cnt_o = cnt;
`endif

endmodule
